// File: rtl/instr_fetch.sv
// Instruction fetch front end: one outstanding bus read at a time, a one-word
// output buffer toward decode, and PC redirects that squash wrong-path fetches.
module instr_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        ireq_ready,
    input  logic        iresp_valid,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        out_fault,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    state_e      state_q;
    logic [63:0] pc_q;
    logic [31:0] buf_q;
    logic        fault_q;
    logic        kill_q;
    logic        redir_misaligned_s;

    function automatic logic misaligned(input logic [63:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

    assign redir_misaligned_s = misaligned(redirect_pc);

    // A misaligned redirect parks fault_q=1 with buf_q=0; if a response is
    // still owed, WAIT drains it first and then presents the fault from HOLD.
    // Fetch state machine: PC, buffer, pending-fault and squash tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            buf_q   <= 32'd0;
            fault_q <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q <= ST_REQ;
                end
                ST_REQ: begin
                    if (redirect_valid) begin
                        pc_q    <= redirect_pc;
                        fault_q <= redir_misaligned_s;
                        if (redir_misaligned_s) begin
                            buf_q <= 32'd0;
                        end
                        if (ireq_ready) begin
                            kill_q  <= 1'b1;
                            state_q <= ST_WAIT;
                        end else if (redir_misaligned_s) begin
                            state_q <= ST_HOLD;
                        end else begin
                            state_q <= ST_REQ;
                        end
                    end else if (ireq_ready) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (redirect_valid) begin
                        pc_q    <= redirect_pc;
                        fault_q <= redir_misaligned_s;
                        if (redir_misaligned_s) begin
                            buf_q <= 32'd0;
                        end
                        if (iresp_valid) begin
                            kill_q  <= 1'b0;
                            state_q <= redir_misaligned_s ? ST_HOLD : ST_REQ;
                        end else begin
                            kill_q  <= 1'b1;
                        end
                    end else if (iresp_valid) begin
                        if (kill_q) begin
                            kill_q  <= 1'b0;
                            state_q <= fault_q ? ST_HOLD : ST_REQ;
                        end else begin
                            buf_q   <= iresp_data;
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid) begin
                        pc_q    <= redirect_pc;
                        fault_q <= redir_misaligned_s;
                        if (redir_misaligned_s) begin
                            buf_q <= 32'd0;
                        end
                        state_q <= redir_misaligned_s ? ST_HOLD : ST_REQ;
                    end else if (out_ready) begin
                        pc_q    <= pc_q + 64'd4;
                        fault_q <= 1'b0;
                        state_q <= ST_REQ;
                    end
                end
                default: begin
                    state_q <= ST_BOOT;
                end
            endcase
        end
    end

    assign ireq_valid = (state_q == ST_REQ);
    assign ireq_addr  = pc_q;
    assign out_valid  = (state_q == ST_HOLD);
    assign out_instr  = buf_q;
    assign out_pc     = pc_q;
    assign out_fault  = fault_q;

endmodule
